// File: rtl/mem_access_stage_if.sv
// Bundle between the memory-access stage, the EX/MEM register, the data RAM and MEM/WB.
// master: the stage itself; slave: the surrounding pipeline and RAM.
interface mem_access_stage_if;
  logic        in_wE_BR;
  logic        in_W_ram;
  logic        in_R_ram;
  logic [31:0] in_DW_alu;
  logic [31:0] in_DR2;
  logic [4:0]  in_wa;
  logic        stall;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic        wb_wE;
  logic [31:0] wb_data;
  logic [4:0]  wb_wa;
  logic        err_misalign;
  logic        err_timeout;

  modport master (
    input  in_wE_BR, in_W_ram, in_R_ram, in_DW_alu, in_DR2, in_wa, ram_rdata, ram_ack,
    output stall, ram_req, ram_we, ram_addr, ram_wdata, wb_wE, wb_data, wb_wa,
           err_misalign, err_timeout
  );

  modport slave (
    output in_wE_BR, in_W_ram, in_R_ram, in_DW_alu, in_DR2, in_wa, ram_rdata, ram_ack,
    input  stall, ram_req, ram_we, ram_addr, ram_wdata, wb_wE, wb_data, wb_wa,
           err_misalign, err_timeout
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: runs one req/ack RAM transaction per load/store, stalls the
// pipeline meanwhile, and registers write-back fields for MEM/WB.
//
// state | meaning
// IDLE  | pass non-memory ops to write-back, launch aligned loads/stores
// REQ   | request outstanding, waiting for ram_ack or timeout
module mem_access_stage #(
  parameter int MAX_WAIT = 15
) (
  input logic             clk,
  input logic             rst,
  mem_access_stage_if.master bus
);
  localparam int CW = ($clog2(MAX_WAIT) > 4) ? $clog2(MAX_WAIT) : 4;

  typedef enum logic {IDLE, REQ} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lat_we, lat_we_nxt;
  logic          lat_rd, lat_rd_nxt;
  logic [4:0]    lat_wa, lat_wa_nxt;
  logic [31:0]   lat_alu, lat_alu_nxt;
  logic          req_q, req_nxt;
  logic          we_q, we_nxt;
  logic [31:0]   addr_q, addr_nxt;
  logic [31:0]   wdata_q, wdata_nxt;
  logic          wb_we_q, wb_we_nxt;
  logic [31:0]   wb_data_q, wb_data_nxt;
  logic [4:0]    wb_wa_q, wb_wa_nxt;
  logic          mis_q, mis_nxt;
  logic          to_q, to_nxt;
  logic          stall_c;
  logic          mem_op;
  logic          aligned;
  logic          last_wait;

  assign mem_op    = bus.in_W_ram | bus.in_R_ram;
  assign aligned   = (bus.in_DW_alu[1:0] == 2'b00);
  assign last_wait = (cnt == CW'(MAX_WAIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_rd    <= 1'b0;
      lat_wa    <= '0;
      lat_alu   <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wb_we_q   <= 1'b0;
      wb_data_q <= '0;
      wb_wa_q   <= '0;
      mis_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lat_we    <= lat_we_nxt;
      lat_rd    <= lat_rd_nxt;
      lat_wa    <= lat_wa_nxt;
      lat_alu   <= lat_alu_nxt;
      req_q     <= req_nxt;
      we_q      <= we_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      wb_we_q   <= wb_we_nxt;
      wb_data_q <= wb_data_nxt;
      wb_wa_q   <= wb_wa_nxt;
      mis_q     <= mis_nxt;
      to_q      <= to_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    lat_we_nxt  = lat_we;
    lat_rd_nxt  = lat_rd;
    lat_wa_nxt  = lat_wa;
    lat_alu_nxt = lat_alu;
    req_nxt     = req_q;
    we_nxt      = we_q;
    addr_nxt    = addr_q;
    wdata_nxt   = wdata_q;
    wb_we_nxt   = wb_we_q;
    wb_data_nxt = wb_data_q;
    wb_wa_nxt   = wb_wa_q;
    mis_nxt     = mis_q;
    to_nxt      = to_q;
    stall_c     = 1'b0;

    case (state)
      IDLE: begin
        if (!mem_op) begin
          wb_we_nxt   = bus.in_wE_BR;
          wb_data_nxt = bus.in_DW_alu;
          wb_wa_nxt   = bus.in_wa;
        end else if (!aligned) begin
          // dropped as a bubble; the pipeline is not held
          mis_nxt     = 1'b1;
          wb_we_nxt   = 1'b0;
          wb_data_nxt = bus.in_DW_alu;
          wb_wa_nxt   = bus.in_wa;
        end else begin
          stall_c     = 1'b1;
          lat_we_nxt  = bus.in_wE_BR;
          lat_rd_nxt  = bus.in_R_ram & ~bus.in_W_ram;
          lat_wa_nxt  = bus.in_wa;
          lat_alu_nxt = bus.in_DW_alu;
          req_nxt     = 1'b1;
          we_nxt      = bus.in_W_ram;
          addr_nxt    = {bus.in_DW_alu[31:2], 2'b00};
          wdata_nxt   = bus.in_DR2;
          cnt_nxt     = '0;
          wb_we_nxt   = 1'b0;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        // release the pipeline in the cycle the transaction ends either way
        stall_c = ~bus.ram_ack & ~last_wait;
        if (bus.ram_ack) begin
          req_nxt     = 1'b0;
          wb_we_nxt   = lat_we;
          wb_wa_nxt   = lat_wa;
          wb_data_nxt = lat_rd ? bus.ram_rdata : lat_alu;
          state_nxt   = IDLE;
        end else if (last_wait) begin
          req_nxt   = 1'b0;
          to_nxt    = 1'b1;
          wb_we_nxt = 1'b0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.stall        = stall_c;
  assign bus.ram_req      = req_q;
  assign bus.ram_we       = we_q;
  assign bus.ram_addr     = addr_q;
  assign bus.ram_wdata    = wdata_q;
  assign bus.wb_wE        = wb_we_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_wa        = wb_wa_q;
  assign bus.err_misalign = mis_q;
  assign bus.err_timeout  = to_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed table rows, a mid-transaction reset, then random
// ops checked against a per-instruction outcome model.
module tb_mem_access_stage;
  localparam int MAX_WAIT = 15;
  localparam int NO_ACK   = 99;

  typedef struct {
    logic        wE, W, R;
    logic [31:0] alu, dr2;
    logic [4:0]  wa;
    int          delay;
    logic [31:0] rdata;
    logic        ack_idle;
    logic        exp_stall;
    int          exp_req;
    logic        exp_wbE;
    logic [31:0] exp_data;
    logic [4:0]  exp_wa;
    logic        exp_mis, exp_to;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [31:0] m_data;
  logic [4:0]  m_wa;
  logic        m_mis, m_to;

  mem_access_stage_if bus ();

  mem_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic op_t mk(input logic wE, W, R, input logic [31:0] alu, dr2,
                             input logic [4:0] wa, input int delay, input logic [31:0] rdata,
                             input logic ack_idle, input logic e_stall, input int e_req,
                             input logic e_wbE, input logic [31:0] e_data,
                             input logic [4:0] e_wa, input logic e_mis, e_to);
    op_t o;
    o.wE = wE; o.W = W; o.R = R; o.alu = alu; o.dr2 = dr2; o.wa = wa;
    o.delay = delay; o.rdata = rdata; o.ack_idle = ack_idle;
    o.exp_stall = e_stall; o.exp_req = e_req; o.exp_wbE = e_wbE;
    o.exp_data = e_data; o.exp_wa = e_wa; o.exp_mis = e_mis; o.exp_to = e_to;
    return o;
  endfunction

  // Outcome of one instruction from the stage's rules, given the RAM latency chosen for it.
  function automatic op_t model(input op_t v);
    op_t o = v;
    o.exp_mis = m_mis;
    o.exp_to  = m_to;
    if (!(v.W || v.R)) begin
      o.exp_stall = 0; o.exp_req = 0;
      o.exp_wbE = v.wE; o.exp_data = v.alu; o.exp_wa = v.wa;
    end else if (v.alu % 4 != 0) begin
      o.exp_stall = 0; o.exp_req = 0; o.exp_mis = 1;
      o.exp_wbE = 0; o.exp_data = v.alu; o.exp_wa = v.wa;
    end else if (v.delay < MAX_WAIT) begin
      o.exp_stall = 1; o.exp_req = v.delay + 1;
      o.exp_wbE = v.wE; o.exp_wa = v.wa;
      o.exp_data = (v.R && !v.W) ? v.rdata : v.alu;
    end else begin
      o.exp_stall = 1; o.exp_req = MAX_WAIT; o.exp_to = 1;
      o.exp_wbE = 0; o.exp_data = m_data; o.exp_wa = m_wa;
    end
    m_data = o.exp_data; m_wa = o.exp_wa; m_mis = o.exp_mis; m_to = o.exp_to;
    return o;
  endfunction

  task automatic scramble_inputs();
    bus.in_wE_BR  = 1'($urandom);
    bus.in_W_ram  = 1'($urandom);
    bus.in_R_ram  = 1'($urandom);
    bus.in_DW_alu = $urandom;
    bus.in_DR2    = $urandom;
    bus.in_wa     = 5'($urandom);
  endtask

  // Entered and left at posedge+1 with the stage in IDLE.
  task automatic run_op(input op_t v, input string tag);
    bus.in_wE_BR  = v.wE;
    bus.in_W_ram  = v.W;
    bus.in_R_ram  = v.R;
    bus.in_DW_alu = v.alu;
    bus.in_DR2    = v.dr2;
    bus.in_wa     = v.wa;
    bus.ram_ack   = v.ack_idle;
    bus.ram_rdata = $urandom;
    #1 chk({tag, " stall_in"}, 32'(bus.stall), 32'(v.exp_stall));
    @(posedge clk); #1;
    for (int k = 0; k < v.exp_req; k++) begin
      chk({tag, " req"}, 32'(bus.ram_req), 32'd1);
      chk({tag, " we"}, 32'(bus.ram_we), 32'(v.W));
      chk({tag, " addr"}, bus.ram_addr, v.alu);
      if (v.W) chk({tag, " wdata"}, bus.ram_wdata, v.dr2);
      if (k == 0) chk({tag, " bubble"}, 32'(bus.wb_wE), 32'd0);
      scramble_inputs();
      bus.ram_ack   = (k == v.delay);
      bus.ram_rdata = (k == v.delay) ? v.rdata : $urandom;
      #1 chk($sformatf("%s stall_req%0d", tag, k), 32'(bus.stall), 32'(k < v.exp_req - 1));
      @(posedge clk); #1;
    end
    bus.ram_ack = 1'b0;
    chk({tag, " req_end"}, 32'(bus.ram_req), 32'd0);
    chk({tag, " wb_wE"}, 32'(bus.wb_wE), 32'(v.exp_wbE));
    chk({tag, " wb_data"}, bus.wb_data, v.exp_data);
    chk({tag, " wb_wa"}, 32'(bus.wb_wa), 32'(v.exp_wa));
    chk({tag, " err_mis"}, 32'(bus.err_misalign), 32'(v.exp_mis));
    chk({tag, " err_to"}, 32'(bus.err_timeout), 32'(v.exp_to));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_data = 0; m_wa = 0; m_mis = 0; m_to = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    op_t tbl[10];
    op_t v;
    int unsigned r;

    // wE W R alu dr2 wa delay rdata ack_idle | stall req wbE data wa mis to
    tbl[0] = mk(1,0,0, 32'h1234, 0, 7, 0, 0, 0,  0, 0, 1, 32'h1234, 7, 0, 0);
    tbl[1] = mk(1,0,1, 32'h10, 0, 3, 1, 32'hDEADBEEF, 0,  1, 2, 1, 32'hDEADBEEF, 3, 0, 0);
    tbl[2] = mk(0,1,0, 32'h20, 32'hCAFEF00D, 4, 0, 32'h5555AAAA, 0,  1, 1, 0, 32'h20, 4, 0, 0);
    tbl[3] = mk(0,0,0, 32'h0, 0, 0, 0, 0, 1,  0, 0, 0, 32'h0, 0, 0, 0);
    tbl[4] = mk(1,1,1, 32'h104, 32'h11112222, 5, 3, 32'h99999999, 0,  1, 4, 1, 32'h104, 5, 0, 0);
    tbl[5] = mk(1,0,1, 32'h13, 0, 6, 0, 0, 0,  0, 0, 0, 32'h13, 6, 1, 0);
    tbl[6] = mk(1,0,1, 32'h80, 0, 8, NO_ACK, 0, 0,  1, MAX_WAIT, 0, 32'h13, 6, 1, 1);
    tbl[7] = mk(0,0,0, 32'h1, 0, 1, 0, 0, 0,  0, 0, 0, 32'h1, 1, 1, 1);
    tbl[8] = mk(1,0,0, 32'h55, 0, 9, 0, 0, 1,  0, 0, 1, 32'h55, 9, 1, 1);
    tbl[9] = mk(1,0,1, 32'hC, 0, 10, MAX_WAIT-1, 32'h12345678, 0,  1, MAX_WAIT, 1, 32'h12345678, 10, 1, 1);

    bus.in_wE_BR = 0; bus.in_W_ram = 0; bus.in_R_ram = 0;
    bus.in_DW_alu = 0; bus.in_DR2 = 0; bus.in_wa = 0;
    bus.ram_rdata = 0; bus.ram_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst req", 32'(bus.ram_req), 32'd0);
    chk("rst wb_wE", 32'(bus.wb_wE), 32'd0);
    chk("rst wb_data", bus.wb_data, 32'd0);
    chk("rst errs", {30'd0, bus.err_misalign, bus.err_timeout}, 32'd0);
    chk("rst stall", 32'(bus.stall), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("row%0d", i));

    // asynchronous reset in the second REQ cycle of a load
    bus.in_wE_BR = 1; bus.in_W_ram = 0; bus.in_R_ram = 1;
    bus.in_DW_alu = 32'h40; bus.in_wa = 5'd11; bus.ram_ack = 0;
    @(posedge clk); #1;
    chk("mid req0", 32'(bus.ram_req), 32'd1);
    @(posedge clk); #1;
    chk("mid req1", 32'(bus.ram_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst req", 32'(bus.ram_req), 32'd0);
    chk("arst wb", {bus.wb_data[30:0], bus.wb_wE}, 32'd0);
    chk("arst wb_wa", 32'(bus.wb_wa), 32'd0);
    chk("arst errs", {30'd0, bus.err_misalign, bus.err_timeout}, 32'd0);
    chk("arst stall", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(mk(1,0,1, 32'h40, 0, 12, 2, 32'hA5A5A5A5, 0,  1, 3, 1, 32'hA5A5A5A5, 12, 0, 0),
           "after_rst");

    do_reset();
    for (int i = 0; i < 300; i++) begin
      v.wE = 1'($urandom); v.dr2 = $urandom; v.wa = 5'($urandom);
      v.rdata = $urandom; v.ack_idle = 1'($urandom); v.alu = $urandom;
      r = $urandom_range(0, 9);
      if (r < 4) begin
        v.W = 0; v.R = 0;
      end else begin
        v.W = 1'($urandom); v.R = v.W ? 1'($urandom) : 1'b1;
        if (r == 4) v.alu[0] = 1'b1;
        else v.alu[1:0] = 2'b00;
      end
      r = $urandom_range(0, 9);
      if (r < 6) v.delay = $urandom_range(0, 3);
      else if (r < 8) v.delay = $urandom_range(4, MAX_WAIT - 1);
      else if (r == 8) v.delay = MAX_WAIT - 1;
      else v.delay = MAX_WAIT;
      run_op(model(v), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
